// File: rtl/id_regfile_sb_pkg.sv
// Shared constants and helpers for the ID-stage register file and its write scoreboard.
// Sizes cover 32 architectural registers, 32-bit data and up to three writes in flight.
package id_regfile_sb_pkg;

   localparam int NREG     = 32;
   localparam int DW       = 32;
   localparam int CW       = 2;
   localparam int AW       = 5;
   localparam int PEND_MAX = (1 << CW) - 1;

   localparam logic [AW-1:0] R0 = '0;

   // An event only counts for a register when enabled and aimed at a real (non-r0) target.
   function automatic logic addr_hit(input logic en, input logic [AW-1:0] a,
                                     input logic [AW-1:0] b);
      return en && (a == b) && (a != R0);
   endfunction

endpackage

// File: rtl/id_regfile_sb_if.sv
// Bundle between the ID/EX/WB pipeline control and the register file with scoreboard.
// The master side is the pipeline; the slave side is id_regfile_sb.
interface id_regfile_sb_if;
   import id_regfile_sb_pkg::*;

   logic [AW-1:0] rs;
   logic [AW-1:0] rt;
   logic          rs_used;
   logic          rt_used;
   logic [DW-1:0] rdata_a;
   logic [DW-1:0] rdata_b;
   logic          id_issue;
   logic          id_wreg;
   logic [AW-1:0] id_destR;
   logic          ex_flush;
   logic          ex_wreg;
   logic [AW-1:0] ex_destR;
   logic          wb_wreg;
   logic [AW-1:0] wb_destR;
   logic [DW-1:0] wb_dest;
   logic          id_stall;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_data;
   logic          sb_err;

   modport master (
      output rs, rt, rs_used, rt_used,
      output id_issue, id_wreg, id_destR,
      output ex_flush, ex_wreg, ex_destR,
      output wb_wreg, wb_destR, wb_dest,
      output dbg_addr,
      input  rdata_a, rdata_b, id_stall, dbg_data, sb_err
   );

   modport slave (
      input  rs, rt, rs_used, rt_used,
      input  id_issue, id_wreg, id_destR,
      input  ex_flush, ex_wreg, ex_destR,
      input  wb_wreg, wb_destR, wb_dest,
      input  dbg_addr,
      output rdata_a, rdata_b, id_stall, dbg_data, sb_err
   );

endinterface

// File: rtl/id_regfile_sb_counter.sv
// Per-register pending-write counter: +1 on issue, -1 on retire, -1 on EX flush.
// Results outside 0..PEND_MAX are clamped and latch a sticky error until reset.
module sb_counter
   import id_regfile_sb_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   input  logic          dec_ret,
   input  logic          dec_flush,
   output logic [CW-1:0] cnt,
   output logic          err
);

   logic signed [CW+1:0] sum;
   logic [CW-1:0]        cnt_next;
   logic                 range_err;

   // Returns {clamped count, out-of-range flag}; the raw sum spans -2..PEND_MAX+1.
   function automatic logic [CW:0] sat_clamp(input logic signed [CW+1:0] s);
      logic signed [CW+1:0] hi;
      hi = (CW+2)'(PEND_MAX);
      if (s > hi)
         return {CW'(PEND_MAX), 1'b1};
      else if (s < 0)
         return {{CW{1'b0}}, 1'b1};
      else
         return {s[CW-1:0], 1'b0};
   endfunction

   always_comb begin
      sum = $signed({2'b00, cnt})
          + $signed({{(CW+1){1'b0}}, inc})
          - $signed({{(CW+1){1'b0}}, dec_ret})
          - $signed({{(CW+1){1'b0}}, dec_flush});
      {cnt_next, range_err} = sat_clamp(sum);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         err <= 1'b0;
      end else begin
         cnt <= cnt_next;
         err <= err | range_err;
      end
   end

endmodule

// File: rtl/id_regfile_sb.sv
// ID-stage register file with same-cycle WB write-through and a stall-only RAW scoreboard.
// Array contents and pending counts are cleared asynchronously by rst.
module id_regfile_sb
   import id_regfile_sb_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   id_regfile_sb_if.slave bus
);

   logic [DW-1:0]   regs [NREG];
   logic [CW-1:0]   pend [NREG];
   logic [NREG-1:0] err_vec;
   logic            iss;
   logic            ret;
   logic            fl;
   logic            stall;

   function automatic logic [DW-1:0] read_port(input logic [AW-1:0] a);
      if (a == R0)
         return '0;
      else if (ret && bus.wb_destR == a)
         return bus.wb_dest;
      else
         return regs[a];
   endfunction

   // A lone outstanding write that retires this cycle is served by the bypass, so it is not a hazard.
   function automatic logic hazard(input logic used, input logic [AW-1:0] a);
      logic [CW-1:0] floor_cnt;
      floor_cnt = (ret && bus.wb_destR == a) ? CW'(1) : '0;
      return used && (a != R0) && (pend[a] > floor_cnt);
   endfunction

   always_comb begin
      stall = hazard(bus.rs_used, bus.rs) | hazard(bus.rt_used, bus.rt);
      iss   = bus.id_issue && !stall && bus.id_wreg && (bus.id_destR != R0);
      ret   = bus.wb_wreg && (bus.wb_destR != R0);
      fl    = bus.ex_flush && bus.ex_wreg && (bus.ex_destR != R0);
   end

   assign bus.id_stall = stall;
   assign bus.rdata_a  = read_port(bus.rs);
   assign bus.rdata_b  = read_port(bus.rt);
   assign bus.dbg_data = (bus.dbg_addr == R0) ? '0 : regs[bus.dbg_addr];
   assign bus.sb_err   = |err_vec;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else if (ret) begin
         regs[bus.wb_destR] <= bus.wb_dest;
      end
   end

   assign pend[0]    = '0;
   assign err_vec[0] = 1'b0;

   for (genvar g = 1; g < NREG; g++) begin : g_pend
      localparam logic [AW-1:0] IDX = AW'(g);

      sb_counter u_cnt (
         .clk       (clk),
         .rst       (rst),
         .inc       (addr_hit(iss, bus.id_destR, IDX)),
         .dec_ret   (addr_hit(ret, bus.wb_destR, IDX)),
         .dec_flush (addr_hit(fl,  bus.ex_destR, IDX)),
         .cnt       (pend[g]),
         .err       (err_vec[g])
      );
   end

endmodule

// File: tb/tb_id_regfile_sb.sv
// Directed bench for id_regfile_sb: a per-cycle vector table plus hand-written
// sequences for dependent-issue stall timing, underflow and asynchronous reset.
module tb_id_regfile_sb;
   import id_regfile_sb_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   id_regfile_sb_if bus ();

   id_regfile_sb dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rs, rt;
      logic        rsu, rtu;
      logic        iss, iwr;
      logic [4:0]  idd;
      logic        fl, flw;
      logic [4:0]  fld;
      logic        wbw;
      logic [4:0]  wbd;
      logic [31:0] wbv;
      logic [4:0]  dbg;
      logic [31:0] ea, eb;
      logic        es;
      logic [31:0] ed;
      logic        ee;
   } vec_t;

   vec_t tbl[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      bus.rs = '0; bus.rt = '0; bus.rs_used = 1'b0; bus.rt_used = 1'b0;
      bus.id_issue = 1'b0; bus.id_wreg = 1'b0; bus.id_destR = '0;
      bus.ex_flush = 1'b0; bus.ex_wreg = 1'b0; bus.ex_destR = '0;
      bus.wb_wreg = 1'b0; bus.wb_destR = '0; bus.wb_dest = '0;
      bus.dbg_addr = '0;
   endtask

   task automatic apply(input vec_t v, input int idx);
      @(negedge clk);
      bus.rs = v.rs; bus.rt = v.rt; bus.rs_used = v.rsu; bus.rt_used = v.rtu;
      bus.id_issue = v.iss; bus.id_wreg = v.iwr; bus.id_destR = v.idd;
      bus.ex_flush = v.fl; bus.ex_wreg = v.flw; bus.ex_destR = v.fld;
      bus.wb_wreg = v.wbw; bus.wb_destR = v.wbd; bus.wb_dest = v.wbv;
      bus.dbg_addr = v.dbg;
      #1;
      chk($sformatf("row%0d rdata_a", idx), bus.rdata_a, v.ea);
      chk($sformatf("row%0d rdata_b", idx), bus.rdata_b, v.eb);
      chk($sformatf("row%0d id_stall", idx), {31'b0, bus.id_stall}, {31'b0, v.es});
      chk($sformatf("row%0d dbg_data", idx), bus.dbg_data, v.ed);
      chk($sformatf("row%0d sb_err", idx), {31'b0, bus.sb_err}, {31'b0, v.ee});
   endtask

   initial begin
      int stalls;
      int issued_at;

      //               rs rt rsu rtu iss iwr idd fl flw fld wbw wbd wbv       dbg ea        eb        es ed        ee
      tbl.push_back('{ 0, 0, 0, 0,  1, 1, 5,  0, 0, 0,  0, 0, 0,         0, 0,        0,        0, 0,        0});
      tbl.push_back('{ 5, 0, 1, 0,  0, 0, 0,  0, 0, 0,  1, 5, 32'h1234,  5, 32'h1234, 0,        0, 0,        0});
      tbl.push_back('{ 5, 0, 1, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,         5, 32'h1234, 0,        0, 32'h1234, 0});
      tbl.push_back('{ 0, 5, 1, 1,  0, 0, 0,  0, 0, 0,  1, 0, 32'hFFFF,  0, 0,        32'h1234, 0, 0,        0});
      tbl.push_back('{ 0, 0, 1, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,         0, 0,        0,        0, 0,        0});
      // add r3, then a reader of r3 stalls two cycles and issues alongside the WB of r3
      tbl.push_back('{ 1, 0, 1, 0,  1, 1, 3,  0, 0, 0,  0, 0, 0,         0, 0,        0,        0, 0,        0});
      tbl.push_back('{ 3, 0, 1, 0,  1, 1, 6,  0, 0, 0,  0, 0, 0,         3, 0,        0,        1, 0,        0});
      tbl.push_back('{ 3, 0, 1, 0,  1, 1, 6,  0, 0, 0,  0, 0, 0,         3, 0,        0,        1, 0,        0});
      tbl.push_back('{ 3, 0, 1, 0,  1, 1, 6,  0, 0, 0,  1, 3, 32'hABCD,  3, 32'hABCD, 0,        0, 0,        0});
      tbl.push_back('{ 6, 3, 1, 1,  0, 0, 0,  0, 0, 0,  0, 0, 0,         3, 0,        32'hABCD, 1, 32'hABCD, 0});
      tbl.push_back('{ 6, 0, 1, 0,  0, 0, 0,  0, 0, 0,  1, 6, 32'h66,    6, 32'h66,   0,        0, 0,        0});
      // r7: pend=2, then issue + retire + flush in one cycle leaves pend=1
      tbl.push_back('{ 0, 0, 0, 0,  1, 1, 7,  0, 0, 0,  0, 0, 0,         0, 0,        0,        0, 0,        0});
      tbl.push_back('{ 0, 0, 0, 0,  1, 1, 7,  0, 0, 0,  0, 0, 0,         0, 0,        0,        0, 0,        0});
      tbl.push_back('{ 7, 0, 0, 0,  1, 1, 7,  1, 1, 7,  1, 7, 32'h77,    7, 32'h77,   0,        0, 0,        0});
      tbl.push_back('{ 7, 0, 1, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,         7, 32'h77,   0,        1, 32'h77,   0});
      tbl.push_back('{ 7, 0, 1, 0,  0, 0, 0,  0, 0, 0,  1, 7, 32'h70,    7, 32'h70,   0,        0, 32'h77,   0});
      tbl.push_back('{ 7, 0, 1, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,         7, 32'h70,   0,        0, 32'h70,   0});
      // lw r4 squashed in EX
      tbl.push_back('{ 0, 0, 0, 0,  1, 1, 4,  0, 0, 0,  0, 0, 0,         0, 0,        0,        0, 0,        0});
      tbl.push_back('{ 4, 0, 1, 0,  0, 0, 0,  1, 1, 4,  0, 0, 0,         0, 0,        0,        1, 0,        0});
      tbl.push_back('{ 4, 0, 1, 0,  1, 0, 0,  0, 0, 0,  0, 0, 0,         0, 0,        0,        0, 0,        0});
      // four issues to r9: saturate at 3, sticky error
      for (int k = 0; k < 4; k++)
         tbl.push_back('{ 0, 0, 0, 0, 1, 1, 9, 0, 0, 0, 0, 0, 0,      0, 0,        0,        0, 0,        0});
      tbl.push_back('{ 9, 0, 1, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,         9, 0,        0,        1, 0,        1});
      tbl.push_back('{ 9, 0, 1, 0,  0, 0, 0,  0, 0, 0,  1, 9, 32'h99,    9, 32'h99,   0,        1, 0,        1});
      tbl.push_back('{ 0, 9, 0, 1,  0, 0, 0,  0, 0, 0,  0, 0, 0,         9, 0,        32'h99,   1, 32'h99,   1});
      // pend[2]=2 ahead of the reset sequence
      tbl.push_back('{ 0, 0, 0, 0,  1, 1, 2,  0, 0, 0,  0, 0, 0,         0, 0,        0,        0, 0,        1});
      tbl.push_back('{ 0, 0, 0, 0,  1, 1, 2,  0, 0, 0,  0, 0, 0,         0, 0,        0,        0, 0,        1});
      tbl.push_back('{ 2, 0, 1, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,         0, 0,        0,        1, 0,        1});

      drive_idle();
      bus.rs = 5'd5; bus.rt = 5'd31; bus.rs_used = 1'b1; bus.rt_used = 1'b1; bus.dbg_addr = 5'd5;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset rdata_a", bus.rdata_a, 32'h0);
      chk("reset rdata_b", bus.rdata_b, 32'h0);
      chk("reset id_stall", {31'b0, bus.id_stall}, 32'h0);
      chk("reset dbg_data", bus.dbg_data, 32'h0);
      chk("reset sb_err", {31'b0, bus.sb_err}, 32'h0);

      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i], i);

      // Asynchronous reset mid-stream, asserted away from any clock edge
      @(negedge clk);
      drive_idle();
      bus.rs = 5'd2; bus.rs_used = 1'b1; bus.rt = 5'd9; bus.rt_used = 1'b1; bus.dbg_addr = 5'd5;
      #1;
      chk("pre-rst id_stall", {31'b0, bus.id_stall}, 32'h1);
      #1;
      rst = 1'b1;
      #1;
      chk("rst id_stall", {31'b0, bus.id_stall}, 32'h0);
      chk("rst rdata_a", bus.rdata_a, 32'h0);
      chk("rst rdata_b", bus.rdata_b, 32'h0);
      chk("rst dbg_data", bus.dbg_data, 32'h0);
      chk("rst sb_err", {31'b0, bus.sb_err}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post-rst id_stall", {31'b0, bus.id_stall}, 32'h0);

      // Producer r12 issued at cycle 0; reader must stall cycles 1-2 and issue in cycle 3 (WB)
      @(negedge clk);
      drive_idle();
      bus.id_issue = 1'b1; bus.id_wreg = 1'b1; bus.id_destR = 5'd12;
      stalls = 0;
      issued_at = -1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         drive_idle();
         bus.rs = 5'd12; bus.rs_used = 1'b1; bus.id_issue = 1'b1;
         bus.wb_wreg = (c == 3); bus.wb_destR = 5'd12; bus.wb_dest = 32'hC0DE;
         #1;
         if (!bus.id_stall) begin
            issued_at = c;
            chk("dep bypass rdata_a", bus.rdata_a, 32'hC0DE);
            break;
         end
         stalls++;
      end
      chk("dep stall cycles", stalls, 32'd2);
      chk("dep issue cycle", issued_at, 32'd3);

      // Retiring r11 with nothing pending underflows and raises the sticky error
      @(negedge clk);
      drive_idle();
      bus.wb_wreg = 1'b1; bus.wb_destR = 5'd11; bus.wb_dest = 32'h11;
      #1;
      chk("underflow sb_err before", {31'b0, bus.sb_err}, 32'h0);
      @(negedge clk);
      drive_idle();
      bus.rs = 5'd11; bus.rs_used = 1'b1;
      #1;
      chk("underflow sb_err after", {31'b0, bus.sb_err}, 32'h1);
      chk("underflow id_stall", {31'b0, bus.id_stall}, 32'h0);
      chk("underflow rdata_a", bus.rdata_a, 32'h11);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
